// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - issue/result bundle for the ALU execute stage
interface alu_exec_unit_if #(
  parameter int XLEN = 32
);
  logic            i_stall;
  logic            i_flush;
  logic            i_issue_valid;
  logic            o_issue_ready;
  logic [3:0]      i_alu_op;
  logic [XLEN-1:0] i_rs1_data;
  logic [XLEN-1:0] i_rs2_data;
  logic [XLEN-1:0] i_imm;
  logic            i_op_b_imm;
  logic [XLEN-1:0] i_pc;
  logic [4:0]      i_rd;
  logic            i_rd_we;
  logic            o_valid;
  logic [XLEN-1:0] o_alu_result;
  logic [4:0]      o_rd;
  logic            o_rd_we;
  logic [XLEN-1:0] o_pc;

  // Execute unit side
  modport slave (
    input  i_stall, i_flush, i_issue_valid, i_alu_op, i_rs1_data, i_rs2_data,
           i_imm, i_op_b_imm, i_pc, i_rd, i_rd_we,
    output o_issue_ready, o_valid, o_alu_result, o_rd, o_rd_we, o_pc
  );

  // Issue/retire side
  modport master (
    output i_stall, i_flush, i_issue_valid, i_alu_op, i_rs1_data, i_rs2_data,
           i_imm, i_op_b_imm, i_pc, i_rd, i_rd_we,
    input  o_issue_ready, o_valid, o_alu_result, o_rd, o_rd_we, o_pc
  );
endinterface

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - single-cycle RV32I integer execute stage
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_exec_unit_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_SLL   = 4'd2,
    OP_SLT   = 4'd3,
    OP_SLTU  = 4'd4,
    OP_XOR   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_OR    = 4'd8,
    OP_AND   = 4'd9,
    OP_LUI   = 4'd10,
    OP_AUIPC = 4'd11,
    OP_LINK  = 4'd12
  } alu_op_e;

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] result;
  logic            legal;
  logic            rd_we_next;

  // Stall is the only source of back-pressure; the unit is otherwise always free
  assign bus.o_issue_ready = ~bus.i_stall;

  assign op_a  = bus.i_rs1_data;
  assign op_b  = bus.i_op_b_imm ? bus.i_imm : bus.i_rs2_data;
  assign shamt = op_b[SHW-1:0];

  // Result mux; codes 13-15 fall through to a zero result flagged illegal
  always_comb begin
    result = '0;
    legal  = 1'b1;
    case (bus.i_alu_op)
      OP_ADD:   result = op_a + op_b;
      OP_SUB:   result = op_a - op_b;
      OP_SLL:   result = op_a << shamt;
      OP_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU:  result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      OP_XOR:   result = op_a ^ op_b;
      OP_SRL:   result = op_a >> shamt;
      OP_SRA:   result = $unsigned($signed(op_a) >>> shamt);
      OP_OR:    result = op_a | op_b;
      OP_AND:   result = op_a & op_b;
      OP_LUI:   result = bus.i_imm;
      OP_AUIPC: result = bus.i_pc + bus.i_imm;
      OP_LINK:  result = bus.i_pc + XLEN'(4);
      default: begin
        result = '0;
        legal  = 1'b0;
      end
    endcase
  end

  // x0 is hardwired zero, so a write to it is never passed to retire
  assign rd_we_next = bus.i_rd_we & (bus.i_rd != 5'd0) & legal;

  // Output register: flush beats stall, stall freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.o_valid      <= 1'b0;
      bus.o_alu_result <= '0;
      bus.o_rd         <= '0;
      bus.o_rd_we      <= 1'b0;
      bus.o_pc         <= '0;
    end else if (bus.i_flush) begin
      bus.o_valid <= 1'b0;
      bus.o_rd_we <= 1'b0;
    end else if (!bus.i_stall) begin
      bus.o_valid <= bus.i_issue_valid;
      if (bus.i_issue_valid) begin
        bus.o_alu_result <= result;
        bus.o_rd         <= bus.i_rd;
        bus.o_rd_we      <= rd_we_next;
        bus.o_pc         <= bus.i_pc;
      end else begin
        bus.o_rd_we <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard bench for alu_exec_unit
module tb_alu_exec_unit;
  logic clk;
  logic rst_n;

  alu_exec_unit_if #(.XLEN(32)) bus ();

  alu_exec_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm,
                                          input logic [31:0] pc);
    logic [31:0] r;
    int sh;
    sh = int'(b & 32'h1f);
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a + (~b) + 32'd1;
      4'd2:  r = a << sh;
      4'd3:  r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
      4'd4:  r = {31'd0, (a < b)};
      4'd5:  r = a ^ b;
      4'd6:  r = a >> sh;
      4'd7:  r = a[31] ? ~((~a) >> sh) : (a >> sh);
      4'd8:  r = a | b;
      4'd9:  r = a & b;
      4'd10: r = imm;
      4'd11: r = pc + imm;
      4'd12: r = pc + 32'd4;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Present an op now (no wait) and record what retire should see one edge later
  task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic bimm, input logic [31:0] pc,
                          input logic [4:0] rd, input logic we, input logic [31:0] exp_res);
    exp_t e;
    bus.i_issue_valid = 1'b1;
    bus.i_alu_op      = op;
    bus.i_rs1_data    = a;
    bus.i_rs2_data    = b;
    bus.i_imm         = imm;
    bus.i_op_b_imm    = bimm;
    bus.i_pc          = pc;
    bus.i_rd          = rd;
    bus.i_rd_we       = we;
    e.res = exp_res;
    e.rd  = rd;
    e.we  = we && (rd != 5'd0) && (op < 4'd13);
    e.pc  = pc;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic bimm, input logic [31:0] pc,
                       input logic [4:0] rd, input logic we, input logic [31:0] exp_res);
    @(negedge clk);
    drive_op(op, a, b, imm, bimm, pc, rd, we, exp_res);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.i_issue_valid = 1'b0;
  endtask

  // Retire-side monitor: an op accepted at this edge must show up just after it
  always @(posedge clk) begin
    logic acc;
    exp_t e;
    acc = rst_n && bus.i_issue_valid && !bus.i_stall && !bus.i_flush;
    #1;
    if (acc) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("o_valid", {31'd0, bus.o_valid}, 32'd1);
        check("o_alu_result", bus.o_alu_result, e.res);
        check("o_rd", {27'd0, bus.o_rd}, {27'd0, e.rd});
        check("o_rd_we", {31'd0, bus.o_rd_we}, {31'd0, e.we});
        check("o_pc", bus.o_pc, e.pc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b, imm, pc;
    logic        bimm;

    rst_n             = 1'b0;
    bus.i_stall       = 1'b0;
    bus.i_flush       = 1'b0;
    bus.i_issue_valid = 1'b1;
    bus.i_alu_op      = 4'd0;
    bus.i_rs1_data    = 32'd9;
    bus.i_rs2_data    = 32'd9;
    bus.i_imm         = 32'd0;
    bus.i_op_b_imm    = 1'b0;
    bus.i_pc          = 32'h40;
    bus.i_rd          = 5'd7;
    bus.i_rd_we       = 1'b1;

    // Reset held across edges with a valid op presented
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    check("rst_result", bus.o_alu_result, 32'd0);
    check("rst_rd", {27'd0, bus.o_rd}, 32'd0);
    check("rst_rd_we", {31'd0, bus.o_rd_we}, 32'd0);
    check("rst_pc", bus.o_pc, 32'd0);

    // First op accepted on the first edge after release
    @(negedge clk);
    rst_n = 1'b1;
    drive_op(4'd0, 32'd5, 32'd7, 32'd0, 1'b0, 32'h0, 5'd3, 1'b1, 32'd12);

    // Register ops with A=0xFFFFFFF0, B=4
    issue(4'd1, 32'hFFFFFFF0, 32'd4, 32'd0, 1'b0, 32'h10, 5'd1, 1'b1, 32'hFFFFFFEC);
    issue(4'd3, 32'hFFFFFFF0, 32'd4, 32'd0, 1'b0, 32'h14, 5'd2, 1'b1, 32'd1);
    issue(4'd4, 32'hFFFFFFF0, 32'd4, 32'd0, 1'b0, 32'h18, 5'd3, 1'b1, 32'd0);
    issue(4'd6, 32'hFFFFFFF0, 32'd4, 32'd0, 1'b0, 32'h1c, 5'd4, 1'b1, 32'h0FFFFFFF);
    issue(4'd7, 32'hFFFFFFF0, 32'd4, 32'd0, 1'b0, 32'h20, 5'd5, 1'b1, 32'hFFFFFFFF);
    issue(4'd2, 32'hFFFFFFF0, 32'd4, 32'd0, 1'b0, 32'h24, 5'd6, 1'b1, 32'hFFFFFF00);
    issue(4'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 32'h28, 5'd7, 1'b1, 32'd0);

    // Immediate and PC-relative ops
    issue(4'd0,  32'd10, 32'd99, 32'hFFFFFFFE, 1'b1, 32'h2c,  5'd8,  1'b1, 32'd8);
    issue(4'd10, 32'd0,  32'd0,  32'h12345000, 1'b1, 32'h30,  5'd9,  1'b1, 32'h12345000);
    issue(4'd11, 32'd0,  32'd0,  32'h2000,     1'b1, 32'h100, 5'd10, 1'b1, 32'h2100);
    issue(4'd12, 32'd0,  32'd0,  32'd0,        1'b0, 32'h200, 5'd11, 1'b1, 32'h204);

    // Writeback gating: x0 destination, rd_we low, illegal opcode
    issue(4'd0,  32'd1, 32'd2, 32'd0, 1'b0, 32'h300, 5'd0,  1'b1, 32'd3);
    issue(4'd8,  32'hF0, 32'h0F, 32'd0, 1'b0, 32'h304, 5'd12, 1'b0, 32'hFF);
    issue(4'd14, 32'd1, 32'd2, 32'd0, 1'b0, 32'h308, 5'd13, 1'b1, 32'd0);
    issue(4'd15, 32'd1, 32'd2, 32'd0, 1'b0, 32'h30c, 5'd14, 1'b1, 32'd0);
    idle();
    @(posedge clk);
    #2;
    check("bubble_valid", {31'd0, bus.o_valid}, 32'd0);
    check("bubble_rd_we", {31'd0, bus.o_rd_we}, 32'd0);

    // Stall: op lands, then three stalled cycles with a different op presented
    issue(4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 32'h400, 5'd4, 1'b1, 32'd3);
    @(negedge clk);
    bus.i_stall       = 1'b1;
    bus.i_issue_valid = 1'b1;
    bus.i_alu_op      = 4'd5;
    bus.i_rs1_data    = 32'hAAAA5555;
    bus.i_rs2_data    = 32'hFFFFFFFF;
    bus.i_pc          = 32'h404;
    bus.i_rd          = 5'd9;
    #1;
    check("stall_ready", {31'd0, bus.o_issue_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      check("stall_valid", {31'd0, bus.o_valid}, 32'd1);
      check("stall_result", bus.o_alu_result, 32'd3);
      check("stall_rd", {27'd0, bus.o_rd}, 32'd4);
      check("stall_pc", bus.o_pc, 32'h400);
    end

    // Flush beats stall and discards the presented op
    @(negedge clk);
    bus.i_flush = 1'b1;
    @(posedge clk);
    #2;
    check("flush_valid", {31'd0, bus.o_valid}, 32'd0);
    check("flush_rd_we", {31'd0, bus.o_rd_we}, 32'd0);
    @(negedge clk);
    bus.i_flush = 1'b0;
    bus.i_stall = 1'b0;
    bus.i_issue_valid = 1'b0;
    #1;
    check("unstall_ready", {31'd0, bus.o_issue_ready}, 32'd1);

    // Back-to-back ADDs, no bubbles
    for (int i = 0; i < 4; i++) begin
      issue(4'd0, 32'd100 * i, 32'd7, 32'd0, 1'b0, 32'h500 + 4 * i, 5'(i + 1), 1'b1,
            32'd100 * i + 32'd7);
    end

    // Random ops against the reference model
    for (int i = 0; i < 24; i++) begin
      op   = 4'($urandom_range(0, 15));
      a    = $urandom;
      b    = $urandom;
      imm  = $urandom;
      pc   = $urandom & 32'hFFFFFFFC;
      bimm = 1'($urandom_range(0, 1));
      issue(op, a, b, imm, bimm, pc, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            ref_alu(op, a, bimm ? imm : b, imm, pc));
    end

    // Asynchronous reset mid-run clears outputs without an edge
    idle();
    repeat (2) @(posedge clk);
    issue(4'd0, 32'd20, 32'd22, 32'd0, 1'b0, 32'h600, 5'd5, 1'b1, 32'd42);
    @(negedge clk);
    bus.i_issue_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, bus.o_valid}, 32'd0);
    check("async_rst_result", bus.o_alu_result, 32'd0);
    check("async_rst_rd_we", {31'd0, bus.o_rd_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(4'd9, 32'hFF00FF00, 32'h0FF00FF0, 32'd0, 1'b0, 32'h700, 5'd31, 1'b1, 32'h0F000F00);
    idle();
    repeat (3) @(posedge clk);
    #2;
    check("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
